// File: rtl/fb_pkg.sv
// Shared framebuffer types and constants: clear-engine state encoding, default geometry
// and the address range check also used by the VGA scan generator.
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  localparam int FB_H_PIX      = 80;
  localparam int FB_V_PIX      = 60;
  localparam int FB_STRIDE_LG2 = 7;
  localparam int FB_DATA_W     = 8;

  // Address is {y, x[stride_lg2-1:0]}; the padding columns past h_pix are not pixels.
  function automatic logic fb_in_range(input logic [31:0] addr,
                                       input int          stride_lg2,
                                       input int          h_pix,
                                       input int          v_pix);
    logic [31:0] x;
    logic [31:0] y;
    x = addr & ((32'd1 << stride_lg2) - 32'd1);
    y = addr >> stride_lg2;
    return (x < 32'(h_pix)) && (y < 32'(v_pix));
  endfunction

endpackage

// File: rtl/fb_clear_engine.sv
// Clear engine: walks every visible pixel once, row by row, writing a latched colour,
// then pulses done for one cycle.
module fb_clear_engine
  import fb_pkg::*;
#(
  parameter int H_PIX      = FB_H_PIX,
  parameter int V_PIX      = FB_V_PIX,
  parameter int STRIDE_LG2 = FB_STRIDE_LG2,
  parameter int DATA_W     = FB_DATA_W,
  localparam int YW        = $clog2(V_PIX),
  localparam int AW        = STRIDE_LG2 + YW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  input  logic [DATA_W-1:0] clr_color,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  localparam logic [STRIDE_LG2-1:0] X_LAST = STRIDE_LG2'(H_PIX - 1);
  localparam logic [YW-1:0]         Y_LAST = YW'(V_PIX - 1);

  clr_state_t              state_q, state_d;
  logic [STRIDE_LG2-1:0]   x_q, x_d;
  logic [YW-1:0]           y_q, y_d;
  logic [DATA_W-1:0]       color_q, color_d;

  // NOTE: every output and next-state variable gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    color_d = color_q;
    wr_en   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          color_d = clr_color;
          x_d     = '0;
          y_d     = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        wr_en = 1'b1;
        if (x_q == X_LAST) begin
          x_d = '0;
          if (y_q == Y_LAST) state_d = DONE;
          else               y_d     = y_q + YW'(1);
        end else begin
          x_d = x_q + STRIDE_LG2'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
    end
  end

  assign busy    = (state_q == CLEAR);
  assign wr_addr = {y_q, x_q};
  assign wr_data = color_q;

endmodule

// File: rtl/ram_fb_param.sv
// Parametrised VGA framebuffer: MCU read/write port, display read port, clear engine and
// sticky error flags. Defining FB_SCROLL_EN adds a vertical scroll offset on the display port.
module ram_fb_param
  import fb_pkg::*;
#(
  parameter int H_PIX      = FB_H_PIX,
  parameter int V_PIX      = FB_V_PIX,
  parameter int STRIDE_LG2 = FB_STRIDE_LG2,
  parameter int DATA_W     = FB_DATA_W,
  localparam int YW        = $clog2(V_PIX),
  localparam int AW        = STRIDE_LG2 + YW
) (
  input  logic              CLK_50MHz,
  input  logic              RST_N,
  input  logic              WE,
  input  logic [AW-1:0]     WA1,
  input  logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] RD1,
  input  logic [AW-1:0]     RA2,
  output logic [DATA_W-1:0] RD2,
  input  logic              CLR_REQ,
  input  logic [DATA_W-1:0] CLR_COLOR,
  output logic              CLR_BUSY,
  output logic              CLR_DONE,
  input  logic              SCROLL_WE,
  input  logic [YW-1:0]     SCROLL_ROW,
  output logic              ERR_OOB,
  output logic              ERR_DROP,
  input  logic              ERR_CLR
);

  localparam int DEPTH = (V_PIX - 1) * (2 ** STRIDE_LG2) + H_PIX;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              eng_we;
  logic [AW-1:0]     eng_wa;
  logic [DATA_W-1:0] eng_wd;
  logic              mem_we;
  logic [AW-1:0]     mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic              drop_set;
  logic              mcu_ok, disp_ok;
  logic [AW-1:0]     disp_addr;
  logic [DATA_W-1:0] rd1_q, rd2_q;
  logic              err_oob_q, err_oob_d;
  logic              err_drop_q, err_drop_d;

  fb_clear_engine #(
    .H_PIX     (H_PIX),
    .V_PIX     (V_PIX),
    .STRIDE_LG2(STRIDE_LG2),
    .DATA_W    (DATA_W)
  ) u_clear (
    .clk      (CLK_50MHz),
    .rst_n    (RST_N),
    .clr_req  (CLR_REQ),
    .clr_color(CLR_COLOR),
    .wr_en    (eng_we),
    .wr_addr  (eng_wa),
    .wr_data  (eng_wd),
    .busy     (CLR_BUSY),
    .done     (CLR_DONE)
  );

  assign mcu_ok  = fb_in_range(32'(WA1), STRIDE_LG2, H_PIX, V_PIX);
  assign disp_ok = fb_in_range(32'(RA2), STRIDE_LG2, H_PIX, V_PIX);

`ifdef FB_SCROLL_EN
  logic [YW-1:0] scroll_q, scroll_d;
  logic [YW:0]   row_sum;

  // Offsets that are not a valid row are ignored so the wrapped row always stays in range.
  always_comb begin
    scroll_d = scroll_q;
    if (SCROLL_WE && ({1'b0, SCROLL_ROW} < (YW+1)'(V_PIX))) scroll_d = SCROLL_ROW;
  end

  always_ff @(posedge CLK_50MHz or negedge RST_N) begin
    if (!RST_N) scroll_q <= '0;
    else        scroll_q <= scroll_d;
  end

  always_comb begin
    row_sum = {1'b0, RA2[AW-1:STRIDE_LG2]} + {1'b0, scroll_q};
    if (row_sum >= (YW+1)'(V_PIX)) row_sum = row_sum - (YW+1)'(V_PIX);
    disp_addr = {row_sum[YW-1:0], RA2[STRIDE_LG2-1:0]};
  end
`else
  logic unused_scroll;
  assign unused_scroll = ^{SCROLL_WE, SCROLL_ROW};
  assign disp_addr     = RA2;
`endif

  // The clear engine owns the write port while busy; MCU writes in that window are dropped.
  always_comb begin
    mem_we   = 1'b0;
    mem_wa   = WA1;
    mem_wd   = WD;
    drop_set = 1'b0;
    if (CLR_BUSY) begin
      mem_we   = eng_we;
      mem_wa   = eng_wa;
      mem_wd   = eng_wd;
      drop_set = WE;
    end else if (WE && mcu_ok) begin
      mem_we = 1'b1;
    end
  end

  // NOTE: the array has no reset so it maps onto block RAM; contents are undefined until written.
  always_ff @(posedge CLK_50MHz) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Read registers live next to the array (read-first on collision); out-of-range reads give 0.
  always_ff @(posedge CLK_50MHz or negedge RST_N) begin
    if (!RST_N) begin
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      rd1_q <= mcu_ok  ? mem[WA1]       : '0;
      rd2_q <= disp_ok ? mem[disp_addr] : '0;
    end
  end

  always_comb begin
    err_oob_d  = ERR_CLR ? 1'b0 : (err_oob_q | ~mcu_ok);
    err_drop_d = ERR_CLR ? 1'b0 : (err_drop_q | drop_set);
  end

  always_ff @(posedge CLK_50MHz or negedge RST_N) begin
    if (!RST_N) begin
      err_oob_q  <= 1'b0;
      err_drop_q <= 1'b0;
    end else begin
      err_oob_q  <= err_oob_d;
      err_drop_q <= err_drop_d;
    end
  end

  assign RD1      = rd1_q;
  assign RD2      = rd2_q;
  assign ERR_OOB  = err_oob_q;
  assign ERR_DROP = err_drop_q;

endmodule

// File: tb/tb_ram_fb_param.sv
// Directed bench for ram_fb_param: table of single-cycle port vectors plus hand-written
// sequences for clear, dropped writes, out-of-range access, scroll and mid-clear reset.
module tb_ram_fb_param;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int YW = 6;
  localparam int NV = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] wa1 = '0;
  logic [DW-1:0] wd = '0;
  logic [DW-1:0] rd1;
  logic [AW-1:0] ra2 = '0;
  logic [DW-1:0] rd2;
  logic          clr_req = 1'b0;
  logic [DW-1:0] clr_color = '0;
  logic          clr_busy, clr_done;
  logic          scroll_we = 1'b0;
  logic [YW-1:0] scroll_row = '0;
  logic          err_oob, err_drop;
  logic          err_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra2;
    logic [DW-1:0] exp_rd1;
    logic [DW-1:0] exp_rd2;
  } vec_t;

  vec_t vecs [NV];

  ram_fb_param dut (
    .CLK_50MHz (clk),
    .RST_N     (rst_n),
    .WE        (we),
    .WA1       (wa1),
    .WD        (wd),
    .RD1       (rd1),
    .RA2       (ra2),
    .RD2       (rd2),
    .CLR_REQ   (clr_req),
    .CLR_COLOR (clr_color),
    .CLR_BUSY  (clr_busy),
    .CLR_DONE  (clr_done),
    .SCROLL_WE (scroll_we),
    .SCROLL_ROW(scroll_row),
    .ERR_OOB   (err_oob),
    .ERR_DROP  (err_drop),
    .ERR_CLR   (err_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] a(input int x, input int y);
    logic [AW-1:0] r;
    r = {y[YW-1:0], x[6:0]};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Runs one clear to completion (bounded) and reports busy cycles and done pulses seen.
  task automatic run_clear(input logic [DW-1:0] color, input int drop_at,
                           output int busy_cnt, output int done_cnt);
    busy_cnt  = 0;
    done_cnt  = 0;
    clr_color = color;
    clr_req   = 1'b1;
    tick();
    clr_req   = 1'b0;
    clr_color = 8'h00;
    for (int i = 0; i < 6000; i++) begin
      if (clr_busy) busy_cnt++;
      if (clr_done) begin
        done_cnt++;
        break;
      end
      we      = (i == drop_at);
      wa1     = a(5, 5);
      wd      = 8'hFF;
      clr_req = (i == 200);
      tick();
    end
    we      = 1'b0;
    clr_req = 1'b0;
  endtask

  initial begin
    int busy_cnt, done_cnt, errs;

    // 0x00 everywhere except the written pixels: each row of the table was hand-derived.
    vecs[0] = '{1'b1, a(10, 3), 8'hA5, a(10, 3), 8'h00, 8'h00};
    vecs[1] = '{1'b0, a(10, 3), 8'h00, a(10, 3), 8'hA5, 8'hA5};
    vecs[2] = '{1'b1, a(79, 59), 8'h3C, a(0, 0), 8'h00, 8'h00};
    vecs[3] = '{1'b0, a(79, 59), 8'h00, a(79, 59), 8'h3C, 8'h3C};
    vecs[4] = '{1'b1, a(0, 0), 8'hFF, a(79, 59), 8'h00, 8'h3C};
    vecs[5] = '{1'b0, a(0, 0), 8'h00, a(80, 0), 8'hFF, 8'h00};
    vecs[6] = '{1'b1, a(11, 3), 8'h5A, a(10, 3), 8'h00, 8'hA5};
    vecs[7] = '{1'b0, a(11, 3), 8'h00, a(11, 3), 8'h5A, 8'h5A};
    vecs[8] = '{1'b1, a(10, 3), 8'h11, a(10, 3), 8'hA5, 8'hA5};
    vecs[9] = '{1'b0, a(10, 3), 8'h00, a(10, 3), 8'h11, 8'h11};

    repeat (3) tick();
    check("rst_rd1", 32'(rd1), 32'h0);
    check("rst_rd2", 32'(rd2), 32'h0);
    check("rst_busy", 32'(clr_busy), 32'h0);
    check("rst_done", 32'(clr_done), 32'h0);
    check("rst_errs", 32'({err_oob, err_drop}), 32'h0);
    rst_n = 1'b1;
    tick();

    run_clear(8'h00, -1, busy_cnt, done_cnt);
    check("init_clear_done", 32'(done_cnt), 32'd1);
    tick();

    for (int i = 0; i < NV; i++) begin
      we  = vecs[i].we;
      wa1 = vecs[i].wa1;
      wd  = vecs[i].wd;
      ra2 = vecs[i].ra2;
      tick();
      check($sformatf("vec%0d_rd1", i), 32'(rd1), 32'(vecs[i].exp_rd1));
      check($sformatf("vec%0d_rd2", i), 32'(rd2), 32'(vecs[i].exp_rd2));
    end
    we = 1'b0;
    check("table_no_oob", 32'(err_oob), 32'h0);

    // Scroll: rows 1 and 3 tagged; offset 58 maps display row 3 to row 1 and row 1 to row 59.
    we = 1'b1; wa1 = a(4, 1); wd = 8'h42; tick();
    wa1 = a(4, 3); wd = 8'h43; tick();
    we = 1'b0; wa1 = a(0, 0);
    scroll_we = 1'b1; scroll_row = 6'd58; tick();
    scroll_we = 1'b0;
    ra2 = a(4, 3); tick();
`ifdef FB_SCROLL_EN
    check("scroll_row3", 32'(rd2), 32'h42);
`else
    check("scroll_row3", 32'(rd2), 32'h43);
`endif
    ra2 = a(4, 1); tick();
`ifdef FB_SCROLL_EN
    check("scroll_wrap", 32'(rd2), 32'h00);
`else
    check("scroll_wrap", 32'(rd2), 32'h42);
`endif
    scroll_we = 1'b1; scroll_row = 6'd0; tick();
    scroll_we = 1'b0;

    // Out-of-range write, then ERR_CLR in the same cycle as another out-of-range access.
    ra2 = a(10, 5);
    we = 1'b1; wa1 = a(90, 5); wd = 8'h77; tick();
    we = 1'b0;
    check("oob_rd1", 32'(rd1), 32'h0);
    check("oob_flag", 32'(err_oob), 32'h1);
    check("oob_neighbour", 32'(rd2), 32'h0);
    err_clr = 1'b1; tick();
    check("oob_clr_wins", 32'(err_oob), 32'h0);
    err_clr = 1'b0; wa1 = a(0, 0); tick();
    check("oob_stays_clear", 32'(err_oob), 32'h0);

    // Full clear with a dropped MCU write at clear cycle 100 and an ignored CLR_REQ.
    run_clear(8'h1C, 100, busy_cnt, done_cnt);
    check("clear_busy_cycles", 32'(busy_cnt), 32'd4800);
    check("clear_done_pulses", 32'(done_cnt), 32'd1);
    check("drop_flag", 32'(err_drop), 32'h1);
    tick();
    check("done_one_cycle", 32'(clr_done), 32'h0);
    check("busy_after_done", 32'(clr_busy), 32'h0);
    errs = 0;
    for (int y = 0; y < 60; y++) begin
      for (int x = 0; x < 80; x++) begin
        ra2 = a(x, y);
        tick();
        if (rd2 !== 8'h1C) errs++;
      end
    end
    check("frame_is_1c", 32'(errs), 32'd0);
    wa1 = a(5, 5); ra2 = a(80, 0); tick();
    check("dropped_pixel", 32'(rd1), 32'h1C);
    check("pad_column", 32'(rd2), 32'h0);
    check("drop_sticky", 32'(err_drop), 32'h1);
    err_clr = 1'b1; tick();
    err_clr = 1'b0;
    check("drop_cleared", 32'(err_drop), 32'h0);

    // Reset after 2000 clear writes: rows 0..24 cleared, rows 25 and up keep 0x1C.
    clr_color = 8'h00; clr_req = 1'b1; tick();
    clr_req = 1'b0;
    repeat (2000) tick();
    check("busy_before_rst", 32'(clr_busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("busy_async_rst", 32'(clr_busy), 32'h0);
    tick();
    check("no_done_in_rst", 32'(clr_done), 32'h0);
    rst_n = 1'b1;
    tick();
    check("no_done_after_rst", 32'(clr_done), 32'h0);
    ra2 = a(0, 0); tick();
    check("partial_row0", 32'(rd2), 32'h00);
    ra2 = a(79, 24); tick();
    check("partial_row24", 32'(rd2), 32'h00);
    ra2 = a(0, 25); tick();
    check("partial_row25", 32'(rd2), 32'h1C);
    ra2 = a(5, 26); tick();
    check("partial_row26", 32'(rd2), 32'h1C);
    ra2 = a(79, 59); tick();
    check("partial_row59", 32'(rd2), 32'h1C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
